pipe_trap_unit: RTL and testbench

- Parametrised trap/exception controller for the 5-stage pipelined core.
- Gathers NCAUSE prioritised exception sources from the pipeline stages and records the exception state in epc/cause/tval.
- Drives the redirect and flush for a multi-cycle pipeline squash, tracks handler residency and performs the return from the handler.
- Replaces the fixed, combinational error-to-erroraddr steering with a programmable trap vector (tvec) and double-fault detection.

---
 rtl/pipe_trap_unit.sv | 91 +++++++++
 tb/tb_pipe_trap_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_trap_unit.sv
// pipe_trap_unit: prioritised trap capture, programmable vector, multi-cycle squash and handler return.
module pipe_trap_unit #(
  parameter int XLEN = 32,
  parameter int NCAUSE = 5,
  parameter logic [XLEN-1:0] TVEC_RST = 32'h00000074,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCAUSE-1:0]        cause_vld,
  input  logic [NCAUSE*XLEN-1:0]   cause_pc,
  input  logic [NCAUSE*XLEN-1:0]   cause_tval,
  input  logic                     ret_req,
  input  logic                     csr_we,
  input  logic [1:0]               csr_sel,
  input  logic [XLEN-1:0]          csr_wdata,
  output logic [XLEN-1:0]          csr_rdata,
  output logic                     redirect,
  output logic [XLEN-1:0]          redirect_pc,
  output logic                     flush,
  output logic                     in_handler,
  output logic                     double_fault
);
  typedef enum logic [1:0] {RUN, FLUSH, HANDLER} state_t;
  state_t state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic tgt, tgt_nxt, take, ret;
  logic [XLEN-1:0] tvec, epc, cause, tval, tvec_nxt, code, tpc, ttval;
  // lowest set index wins: scan downwards so the last hit is the winner
  always_comb begin
    code = '0;
    tpc = '0;
    ttval = '0;
    for (int i = NCAUSE - 1; i >= 0; i--)
      if (cause_vld[i]) begin
        code = XLEN'(i + 1);
        tpc = cause_pc[i*XLEN +: XLEN];
        ttval = cause_tval[i*XLEN +: XLEN];
      end
  end
  assign take = state != FLUSH && |cause_vld;
  assign ret = state == HANDLER && ret_req && !(|cause_vld);
  assign tvec_nxt = csr_we && csr_sel == 2'd0 ? csr_wdata : tvec;
  assign flush = state == FLUSH;
  assign csr_rdata = csr_sel == 2'd0 ? tvec : csr_sel == 2'd1 ? epc : csr_sel == 2'd2 ? cause : tval;
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    tgt_nxt = tgt;
    if (take || ret) begin
      state_nxt = FLUSH;
      cnt_nxt = 3'(FLUSH_CYCLES - 1);
      tgt_nxt = take;
    end else if (state == FLUSH) begin
      state_nxt = cnt == 3'd0 ? (tgt ? HANDLER : RUN) : FLUSH;
      cnt_nxt = cnt == 3'd0 ? cnt : cnt - 3'd1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      cnt <= '0;
      tgt <= 1'b0;
      tvec <= TVEC_RST;
      epc <= '0;
      cause <= '0;
      tval <= '0;
      redirect <= 1'b0;
      redirect_pc <= '0;
      in_handler <= 1'b0;
      double_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      tgt <= tgt_nxt;
      tvec <= tvec_nxt;
      redirect <= take || ret;
      redirect_pc <= take ? tvec_nxt : ret ? epc : redirect_pc;
      in_handler <= state == FLUSH && cnt == 3'd0 ? tgt : in_handler;
      double_fault <= double_fault | (take && in_handler);
      if (take) begin
        epc <= tpc;
        tval <= ttval;
        cause <= {in_handler, code[XLEN-2:0]};
      end else if (csr_we) begin
        epc <= csr_sel == 2'd1 ? csr_wdata : epc;
        cause <= csr_sel == 2'd2 ? csr_wdata | {double_fault, {(XLEN-1){1'b0}}} : cause;
        tval <= csr_sel == 2'd3 ? csr_wdata : tval;
      end
    end
endmodule

// File: tb/tb_pipe_trap_unit.sv
// tb_pipe_trap_unit: directed scenarios plus randomized traffic against a behavioural trap model.
module tb_pipe_trap_unit;
  localparam int NC = 5;
  localparam int FC = 3;
  logic clk = 0, rst = 0;
  logic [NC-1:0] cause_vld = '0;
  logic [NC*32-1:0] cause_pc = '0, cause_tval = '0;
  logic ret_req = 0, csr_we = 0;
  logic [1:0] csr_sel = 0;
  logic [31:0] csr_wdata = 0, csr_rdata, redirect_pc;
  logic redirect, flush, in_handler, double_fault;
  int errors = 0, checks = 0;
  int m_fl;
  bit m_in, m_tgt, m_df, m_redir;
  logic [31:0] m_tvec, m_epc, m_cause, m_tval, m_rpc;

  pipe_trap_unit dut (
    .clk(clk), .rst(rst), .cause_vld(cause_vld), .cause_pc(cause_pc), .cause_tval(cause_tval),
    .ret_req(ret_req), .csr_we(csr_we), .csr_sel(csr_sel), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .in_handler(in_handler), .double_fault(double_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_csr(input logic [1:0] s);
    return s == 0 ? m_tvec : s == 1 ? m_epc : s == 2 ? m_cause : m_tval;
  endfunction

  task automatic model_reset();
    m_fl = 0; m_in = 0; m_tgt = 0; m_df = 0; m_redir = 0;
    m_tvec = 32'h74; m_epc = 0; m_cause = 0; m_tval = 0; m_rpc = 0;
  endtask

  // one clock edge: advance the model with the inputs seen at that edge
  task automatic tick();
    int k;
    bit any, trap, retn;
    @(posedge clk);
    any = |cause_vld;
    k = 0;
    for (int i = 0; i < NC; i++) if (cause_vld[i]) begin k = i; break; end
    trap = m_fl == 0 && any;
    retn = m_fl == 0 && m_in && ret_req && !any;
    if (csr_we && csr_sel == 0) m_tvec = csr_wdata;
    if (trap) begin
      m_epc = cause_pc[k*32 +: 32];
      m_tval = cause_tval[k*32 +: 32];
      m_cause = (k + 1) + (m_in ? 32'h80000000 : 32'h0);
      if (m_in) m_df = 1;
      m_redir = 1; m_rpc = m_tvec; m_fl = FC; m_tgt = 1;
    end else begin
      if (retn) begin
        m_redir = 1; m_rpc = m_epc; m_fl = FC; m_tgt = 0;
      end else begin
        m_redir = 0;
        if (m_fl > 0) begin
          m_fl--;
          if (m_fl == 0) m_in = m_tgt;
        end
      end
      if (csr_we && csr_sel == 1) m_epc = csr_wdata;
      if (csr_we && csr_sel == 2) m_cause = csr_wdata | (m_df ? 32'h80000000 : 32'h0);
      if (csr_we && csr_sel == 3) m_tval = csr_wdata;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp [4] = '{32'h74, 0, 0, 0};
    rst = 1;
    model_reset();
    #1;
    for (int s = 0; s < 4; s++) begin
      csr_sel = 2'(s); #1; checks++;
      if (csr_rdata !== exp[s]) begin errors++; $display("FAIL reset_csr%0d got=%h exp=%h", s, csr_rdata, exp[s]); end
    end
    checks++;
    if ({redirect, flush, in_handler, double_fault} !== 4'b0 || redirect_pc !== 0) begin
      errors++; $display("FAIL reset_strobes got=%b%b%b%b pc=%h exp=0000 pc=0", redirect, flush, in_handler, double_fault, redirect_pc);
    end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_trap();
    cause_vld = 5'b01000; cause_pc[3*32 +: 32] = 32'h40; cause_tval[3*32 +: 32] = 32'h81;
    tick();
    cause_vld = 0; checks++;
    if (redirect !== 1 || redirect_pc !== 32'h74 || flush !== 1) begin
      errors++; $display("FAIL trap_redirect got=%b pc=%h flush=%b exp=1 pc=74 flush=1", redirect, redirect_pc, flush);
    end
    for (int c = 2; c <= FC; c++) begin
      tick(); checks++;
      if (redirect !== 0 || flush !== 1 || in_handler !== 0) begin
        errors++; $display("FAIL trap_flush%0d got red=%b fl=%b ih=%b exp 0 1 0", c, redirect, flush, in_handler);
      end
    end
    tick(); checks++;
    if (flush !== 0 || in_handler !== 1) begin errors++; $display("FAIL trap_enter got fl=%b ih=%b exp 0 1", flush, in_handler); end
    csr_sel = 1; #1; checks++;
    if (csr_rdata !== 32'h40) begin errors++; $display("FAIL trap_epc got=%h exp=40", csr_rdata); end
    csr_sel = 2; #1; checks++;
    if (csr_rdata !== 32'h4) begin errors++; $display("FAIL trap_cause got=%h exp=4", csr_rdata); end
    csr_sel = 3; #1; checks++;
    if (csr_rdata !== 32'h81) begin errors++; $display("FAIL trap_tval got=%h exp=81", csr_rdata); end
  endtask

  task automatic do_return(input logic [31:0] exp_pc, input string nm);
    ret_req = 1; tick(); ret_req = 0; checks++;
    if (redirect !== 1 || redirect_pc !== exp_pc || flush !== 1 || in_handler !== 1) begin
      errors++; $display("FAIL %s_ret got red=%b pc=%h fl=%b ih=%b exp 1 %h 1 1", nm, redirect, redirect_pc, flush, in_handler, exp_pc);
    end
    repeat (FC - 1) tick();
    checks++;
    if (flush !== 1 || in_handler !== 1) begin errors++; $display("FAIL %s_ret_last got fl=%b ih=%b exp 1 1", nm, flush, in_handler); end
    tick(); checks++;
    if (flush !== 0 || in_handler !== 0) begin errors++; $display("FAIL %s_ret_exit got fl=%b ih=%b exp 0 0", nm, flush, in_handler); end
  endtask

  task automatic test_return();
    do_return(32'h40, "return");
    ret_req = 1; tick(); ret_req = 0; checks++;
    if (redirect !== 0 || flush !== 0) begin errors++; $display("FAIL ret_in_run got red=%b fl=%b exp 0 0", redirect, flush); end
  endtask

  task automatic test_priority();
    for (int i = 0; i < NC; i++) begin
      cause_pc[i*32 +: 32] = 32'h100 + 4 * i; cause_tval[i*32 +: 32] = 32'h900 + i;
    end
    cause_vld = 5'b10110; tick();
    cause_vld = 5'b00001; tick(); tick();
    cause_vld = 0; tick();
    checks++;
    if (in_handler !== 1 || double_fault !== 0 || flush !== 0) begin
      errors++; $display("FAIL prio_state got ih=%b df=%b fl=%b exp 1 0 0", in_handler, double_fault, flush);
    end
    csr_sel = 2; #1; checks++;
    if (csr_rdata !== 32'h2) begin errors++; $display("FAIL prio_cause got=%h exp=2", csr_rdata); end
    csr_sel = 1; #1; checks++;
    if (csr_rdata !== 32'h104) begin errors++; $display("FAIL prio_epc got=%h exp=104", csr_rdata); end
  endtask

  task automatic test_double_fault();
    cause_pc[0 +: 32] = 32'h200;
    cause_vld = 5'b00001; tick(); cause_vld = 0; checks++;
    if (double_fault !== 1 || redirect !== 1 || in_handler !== 1) begin
      errors++; $display("FAIL df_set got df=%b red=%b ih=%b exp 1 1 1", double_fault, redirect, in_handler);
    end
    repeat (FC) tick();
    csr_sel = 2; #1; checks++;
    if (csr_rdata !== 32'h80000001) begin errors++; $display("FAIL df_cause got=%h exp=80000001", csr_rdata); end
    csr_sel = 1; #1; checks++;
    if (csr_rdata !== 32'h200) begin errors++; $display("FAIL df_epc got=%h exp=200", csr_rdata); end
    do_return(32'h200, "df");
    checks++;
    if (double_fault !== 1) begin errors++; $display("FAIL df_sticky got=%b exp=1", double_fault); end
  endtask

  task automatic test_csr_trap_and_reset();
    csr_we = 1; csr_sel = 0; csr_wdata = 32'h60; cause_vld = 5'b00100;
    tick();
    csr_we = 0; cause_vld = 0; checks++;
    if (redirect !== 1 || redirect_pc !== 32'h60) begin errors++; $display("FAIL csr_trap_pc got red=%b pc=%h exp 1 60", redirect, redirect_pc); end
    csr_sel = 2; #1; checks++;
    if (csr_rdata !== 32'h3) begin errors++; $display("FAIL csr_trap_cause got=%h exp=3", csr_rdata); end
    tick();
    #2 rst = 1; #1; model_reset(); csr_sel = 0; #1; checks++;
    if (flush !== 0 || redirect !== 0 || in_handler !== 0 || double_fault !== 0 || csr_rdata !== 32'h74) begin
      errors++; $display("FAIL reset_mid_flush got fl=%b red=%b ih=%b df=%b tvec=%h exp 0 0 0 0 74", flush, redirect, in_handler, double_fault, csr_rdata);
    end
    @(negedge clk); rst = 0;
    tick(); checks++;
    if (flush !== 0 || redirect !== 0) begin errors++; $display("FAIL post_reset_idle got fl=%b red=%b exp 0 0", flush, redirect); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      cause_vld = $urandom_range(0, 4) == 0 ? NC'($urandom) : '0;
      for (int i = 0; i < NC; i++) begin
        cause_pc[i*32 +: 32] = $urandom; cause_tval[i*32 +: 32] = $urandom;
      end
      ret_req = $urandom_range(0, 2) == 0;
      csr_we = $urandom_range(0, 5) == 0;
      csr_sel = 2'($urandom);
      csr_wdata = $urandom;
      tick();
      checks++;
      if (redirect !== m_redir || flush !== (m_fl > 0) || in_handler !== m_in || double_fault !== m_df ||
          (m_redir && redirect_pc !== m_rpc) || csr_rdata !== m_csr(csr_sel)) begin
        errors++;
        $display("FAIL random@%0d got red=%b pc=%h fl=%b ih=%b df=%b rd=%h exp red=%b pc=%h fl=%b ih=%b df=%b rd=%h",
                 n, redirect, redirect_pc, flush, in_handler, double_fault, csr_rdata,
                 m_redir, m_rpc, m_fl > 0, m_in, m_df, m_csr(csr_sel));
      end
    end
    cause_vld = 0; ret_req = 0; csr_we = 0;
  endtask

  initial begin
    test_reset();
    test_trap();
    test_return();
    test_priority();
    test_double_fault();
    test_csr_trap_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
